free_reg_list: RTL and testbench
================================

Name: free_reg_list

Overview:
- Circular free list of physical register indices. Supplies the rename stage with a window of free registers each cycle, `free_register_data` / `frl_valid`.
- Accepts the per-slot consumption mask `frl_ready` back from rename.
- Reclaims physical registers released by ROB commit.
- Sits between the rename table (consumer) and the ROB commit path (producer of freed regs).

Parameters:
- NUM_PHYS_REGS, 128, total physical registers; power of two.
- NUM_ARCH_REGS, 32, architectural GPRs. Phys regs 0..NUM_ARCH_REGS (including one NZCV reg) are mapped at reset and never start in the list.
- ALLOC_WIDTH, 6, registers presented per cycle (2*INSTR_Q_WIDTH+2).
- FREE_WIDTH, 2, release ports from ROB commit.

Ports:
- clk  in  1  clock
- rst_in  in  1  synchronous active-high reset
- frl_ready  in  ALLOC_WIDTH  per-slot consume mask for the current window
- free_register_data  out  ALLOC_WIDTH x $clog2(NUM_PHYS_REGS)  current window, slot 0 = head
- frl_valid  out  1  window holds ALLOC_WIDTH valid free registers
- free_valid  in  FREE_WIDTH  release strobe per port
- free_reg  in  FREE_WIDTH x $clog2(NUM_PHYS_REGS)  released register index per port
- free_count  out  $clog2(NUM_PHYS_REGS)+1  entries currently in the list
- frl_error  out  1  sticky error flag (see Optional Feature)

Behaviour:
- **Storage:** NUM_PHYS_REGS-entry array, head/tail pointers of $clog2(NUM_PHYS_REGS) bits, wrapping modulo NUM_PHYS_REGS, plus an explicit count register.
- **Reset:**
  - Array holds NUM_ARCH_REGS+1 .. NUM_PHYS_REGS-1 in ascending order; head=0, tail=count=NUM_PHYS_REGS-NUM_ARCH_REGS-1 (95).
  - Outputs after reset: `free_register_data` = 33..38, `frl_valid`=1, `frl_error`=0.
  - Reset mid-operation discards all state and restores this image the next cycle.
- **Window and valid:**
  - `free_register_data[k]` = array[head+k] (modulo wrap), continuously.
  - `frl_valid` = (count >= ALLOC_WIDTH).
- **Take cycle:** a cycle with `frl_valid`=1 and `frl_ready`!=0.
  - head advances by ALLOC_WIDTH.
  - Slots with `frl_ready[k]`=1 are consumed.
  - Slots with `frl_ready[k]`=0 are recycled: their indices are written at the tail in ascending slot order. This lets rename leave fixed slots (e.g. immediate slots) unused without losing registers.
- **frl_ready ignored:** when `frl_valid`=0 or the mask is 0, nothing moves.
- **Release:** each `free_valid[p]` appends `free_reg[p]` at the tail, after any recycled slots, in port order. Same cycle as a take is legal.
- **Count update:** count_next = count - popcount(consumed) + popcount(free_valid). Tail advances by (recycled + released).
- **Update latency:** one cycle; the new window is visible the cycle after the take.
- **Overflow:** count_next > NUM_PHYS_REGS is a protocol violation.
  - Simulation assertion fires.
  - Excess writes are dropped; count saturates at NUM_PHYS_REGS.
- **Empty / low:** count < ALLOC_WIDTH holds `frl_valid` low until releases refill the list. Partial windows are never presented as valid.

Optional Feature:
- Macro: FRL_DOUBLE_FREE_CHECK_EN.
- **With the macro defined:**
  - Adds a NUM_PHYS_REGS-bit in_list vector, set on insert and cleared on consume.
  - A release of a register already in_list, or of an index <= NUM_ARCH_REGS that was never allocated, is dropped: not enqueued, not counted.
  - Such a release sets `frl_error`, sticky until reset.
  - Two ports releasing the same index in one cycle: port 0 is accepted, port 1 is flagged.
- **Without the macro:** no vector is built, all releases are accepted, `frl_error` is tied 0.

Test Plan:
- Reset -> `free_register_data`=33..38, `frl_valid`=1, `free_count`=95; pulse reset mid-stream -> same image next cycle.
- `frl_ready`=6'b111111 once -> next cycle window 39..44, `free_count`=89.
- `frl_ready`=6'b110011 from reset -> `free_count`=91, window 39..44; drain the list fully -> 35,36 appear last, in that order.
- Consume full windows until `free_count`=5 -> `frl_valid`=0; `frl_ready`=6'b111111 -> no change. Release 40 and 41 -> `free_count`=7, `frl_valid`=1.
- Take with `frl_ready`=6'b111111 and `free_valid`=2'b11 (regs 33,34) in the same cycle -> `free_count`=91; 33,34 enqueued at tail in port order.
- With FRL_DOUBLE_FREE_CHECK_EN: release 50 while 50 is still in the list -> `free_count` unchanged, `frl_error`=1 and stays 1 until reset.

Source files
------------

// File: rtl/free_reg_list.sv
// free_reg_list: circular free list of physical register indices.
// Presents a window of ALLOC_WIDTH free registers to rename, takes back the
// unused slots of each take, and reclaims registers released by ROB commit.
// Optional build macro FRL_DOUBLE_FREE_CHECK_EN adds double-free filtering
// and a sticky frl_error flag; without it frl_error is tied low.
module free_reg_list #(
  parameter int NUM_PHYS_REGS = 128,
  parameter int NUM_ARCH_REGS = 32,
  parameter int ALLOC_WIDTH   = 6,
  parameter int FREE_WIDTH    = 2,
  localparam int IDX_W        = $clog2(NUM_PHYS_REGS),
  localparam int CNT_W        = IDX_W + 1
) (
  input  logic                                clk,
  input  logic                                rst_in,
  input  logic [ALLOC_WIDTH-1:0]              frl_ready,
  output logic [ALLOC_WIDTH-1:0][IDX_W-1:0]   free_register_data,
  output logic                                frl_valid,
  input  logic [FREE_WIDTH-1:0]               free_valid,
  input  logic [FREE_WIDTH-1:0][IDX_W-1:0]    free_reg,
  output logic [CNT_W-1:0]                    free_count,
  output logic                                frl_error
);

  localparam int NUM_WR      = ALLOC_WIDTH + FREE_WIDTH;
  localparam int RESET_COUNT = NUM_PHYS_REGS - NUM_ARCH_REGS - 1;

  logic [IDX_W-1:0] list_q [NUM_PHYS_REGS];
  logic [IDX_W-1:0] head_q, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, cnt_after_take;

  logic                         take;
  logic [FREE_WIDTH-1:0]        release_ok;
  logic [NUM_WR-1:0]            wr_valid;
  logic [NUM_WR-1:0][IDX_W-1:0] wr_addr;
  logic [NUM_WR-1:0][IDX_W-1:0] wr_data;
  logic                         overflow;

  // Window: the ALLOC_WIDTH entries starting at head, wrapping naturally.
  always_comb begin
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      free_register_data[k] = list_q[head_q + IDX_W'(k)];
    end
  end

  assign frl_valid  = (count_q >= CNT_W'(ALLOC_WIDTH));
  assign free_count = count_q;
  assign take       = frl_valid && (frl_ready != '0);

`ifdef FRL_DOUBLE_FREE_CHECK_EN
  logic [NUM_PHYS_REGS-1:0] in_list_q, in_list_d;
  logic [FREE_WIDTH-1:0]    release_bad;
  logic                     error_q;

  // Release filter: drop releases of registers already in the list, and a
  // second port repeating an index that an earlier port already returned.
  // Reset-mapped registers 0..NUM_ARCH_REGS are treated as allocated, so
  // their first release is legal and any repeat is caught by in_list.
  always_comb begin
    logic dup;
    release_ok  = '0;
    release_bad = '0;
    for (int p = 0; p < FREE_WIDTH; p++) begin
      dup = in_list_q[free_reg[p]];
      for (int q = 0; q < p; q++) begin
        if (release_ok[q] && (free_reg[q] == free_reg[p])) dup = 1'b1;
      end
      if (free_valid[p]) begin
        release_ok[p]  = !dup;
        release_bad[p] = dup;
      end
    end
  end

  // Membership update: consumed slots leave, every written entry joins.
  always_comb begin
    in_list_d = in_list_q;
    if (take) begin
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
        if (frl_ready[k]) in_list_d[free_register_data[k]] = 1'b0;
      end
    end
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_valid[j]) in_list_d[wr_data[j]] = 1'b1;
    end
  end

  // Membership vector and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        in_list_q[i] <= (i > NUM_ARCH_REGS);
      end
      error_q <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      error_q   <= error_q | (|release_bad);
    end
  end

  assign frl_error = error_q;
`else
  assign release_ok = free_valid;
  assign frl_error  = 1'b0;
`endif

  // Write plan: recycled slots in ascending slot order, then releases in
  // port order, all packed consecutively from the tail. Anything that would
  // push the count past NUM_PHYS_REGS is dropped.
  // NOTE: every output of this block gets a default before any branch, so
  // no path leaves a value held and no latch is inferred.
  always_comb begin
    int n;
    int space;
    wr_valid = '0;
    wr_addr  = '0;
    wr_data  = '0;
    overflow = 1'b0;
    n        = 0;
    cnt_after_take = take ? count_q - CNT_W'(ALLOC_WIDTH) : count_q;
    space    = NUM_PHYS_REGS - int'(cnt_after_take);
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      if (take && !frl_ready[k]) begin
        wr_valid[n] = 1'b1;
        wr_addr[n]  = tail_q + IDX_W'(n);
        wr_data[n]  = free_register_data[k];
        n++;
      end
    end
    for (int p = 0; p < FREE_WIDTH; p++) begin
      if (release_ok[p]) begin
        if (n < space) begin
          wr_valid[n] = 1'b1;
          wr_addr[n]  = tail_q + IDX_W'(n);
          wr_data[n]  = free_reg[p];
          n++;
        end else begin
          overflow = 1'b1;
        end
      end
    end
    count_d = cnt_after_take + CNT_W'(n);
    tail_d  = tail_q + IDX_W'(n);
  end

  // List storage and pointers.
  // NOTE: the array is reset because the initial free pool is part of the
  // reset image; a plain RAM without reset could not restore it in a cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        list_q[i] <= (i < RESET_COUNT) ? IDX_W'(NUM_ARCH_REGS + 1 + i) : '0;
      end
      head_q  <= '0;
      tail_q  <= IDX_W'(RESET_COUNT);
      count_q <= CNT_W'(RESET_COUNT);
    end else begin
      if (take) head_q <= head_q + IDX_W'(ALLOC_WIDTH);
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_valid[j]) list_q[wr_addr[j]] <= wr_data[j];
      end
    end
  end

`ifndef SYNTHESIS
  // Releasing more registers than the list can hold is a protocol violation.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst_in) !overflow);
`endif

endmodule

// File: tb/tb_free_reg_list.sv
// tb_free_reg_list: table-driven vectors plus hand-written sequences for
// free_reg_list, checked against a queue model through a scoreboard.
module tb_free_reg_list;

  localparam int N  = 128;
  localparam int A  = 32;
  localparam int AW = 6;
  localparam int FW = 2;
  localparam int IW = 7;

  logic                   clk = 1'b0;
  logic                   rst_in = 1'b1;
  logic [AW-1:0]          frl_ready = '0;
  logic [AW-1:0][IW-1:0]  free_register_data;
  logic                   frl_valid;
  logic [FW-1:0]          free_valid = '0;
  logic [FW-1:0][IW-1:0]  free_reg = '0;
  logic [IW:0]            free_count;
  logic                   frl_error;

  always #5 clk = ~clk;

  free_reg_list #(
    .NUM_PHYS_REGS(N), .NUM_ARCH_REGS(A), .ALLOC_WIDTH(AW), .FREE_WIDTH(FW)
  ) dut (
    .clk(clk),
    .rst_in(rst_in),
    .frl_ready(frl_ready),
    .free_register_data(free_register_data),
    .frl_valid(frl_valid),
    .free_valid(free_valid),
    .free_reg(free_reg),
    .free_count(free_count),
    .frl_error(frl_error)
  );

  typedef struct {
    int count;
    bit valid;
    bit err;
    int win[AW];
  } exp_t;

  typedef struct {
    bit            rst;
    logic [AW-1:0] rdy;
    logic [FW-1:0] fv;
    int            r0;
    int            r1;
    int            exp_count;
    bit            exp_valid;
    int            exp_head;
  } vec_t;

  exp_t sb_q[$];
  int   model_q[$];
  bit   model_err = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic bit model_has(input int r);
    foreach (model_q[i]) if (model_q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: update the model, queue the expectation, drive, compare.
  task automatic step(input bit rst, input logic [AW-1:0] rdy,
                      input logic [FW-1:0] fv, input int r0, input int r1);
    exp_t e;
    int   taken[AW];
    int   rel[FW];
    bit   acc[FW];
    rel[0] = r0;
    rel[1] = r1;
    if (rst) begin
      model_q.delete();
      for (int i = A + 1; i < N; i++) model_q.push_back(i);
      model_err = 1'b0;
    end else begin
      for (int p = 0; p < FW; p++) begin
        acc[p] = fv[p];
`ifdef FRL_DOUBLE_FREE_CHECK_EN
        if (fv[p]) begin
          if (model_has(rel[p]) || (p == 1 && acc[0] && rel[0] == rel[1])) begin
            acc[p]    = 1'b0;
            model_err = 1'b1;
          end
        end
`endif
      end
      if (model_q.size() >= AW && rdy != '0) begin
        for (int k = 0; k < AW; k++) taken[k] = model_q.pop_front();
        for (int k = 0; k < AW; k++) if (!rdy[k]) model_q.push_back(taken[k]);
      end
      for (int p = 0; p < FW; p++) if (acc[p]) model_q.push_back(rel[p]);
    end
    e.count = model_q.size();
    e.valid = (e.count >= AW);
    e.err   = model_err;
    for (int k = 0; k < AW; k++) e.win[k] = (k < model_q.size()) ? model_q[k] : -1;
    sb_q.push_back(e);

    rst_in      = rst;
    frl_ready   = rdy;
    free_valid  = fv;
    free_reg[0] = IW'(r0);
    free_reg[1] = IW'(r1);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("count", int'(free_count), e.count);
    check("valid", int'(frl_valid), int'(e.valid));
    check("error", int'(frl_error), int'(e.err));
    for (int k = 0; k < AW; k++) begin
      if (e.win[k] >= 0) check($sformatf("win%0d", k), int'(free_register_data[k]), e.win[k]);
    end
    rst_in     = 1'b0;
    frl_ready  = '0;
    free_valid = '0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 6'b000000, 2'b00,  0,  0, 95, 1'b1, 33};
    vecs[1] = '{1'b0, 6'b111111, 2'b00,  0,  0, 89, 1'b1, 39};
    vecs[2] = '{1'b0, 6'b110011, 2'b00,  0,  0, 85, 1'b1, 45};
    vecs[3] = '{1'b0, 6'b000000, 2'b11, 39, 40, 87, 1'b1, 45};
    vecs[4] = '{1'b1, 6'b000000, 2'b00,  0,  0, 95, 1'b1, 33};
    vecs[5] = '{1'b0, 6'b110011, 2'b00,  0,  0, 91, 1'b1, 39};
    vecs[6] = '{1'b1, 6'b000000, 2'b00,  0,  0, 95, 1'b1, 33};
`ifdef FRL_DOUBLE_FREE_CHECK_EN
    // 33 and 34 are still in the list while being taken: both rejected.
    vecs[7] = '{1'b0, 6'b111111, 2'b11, 33, 34, 89, 1'b1, 39};
`else
    vecs[7] = '{1'b0, 6'b111111, 2'b11, 33, 34, 91, 1'b1, 39};
`endif

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rst, vecs[i].rdy, vecs[i].fv, vecs[i].r0, vecs[i].r1);
      check($sformatf("tbl%0d_count", i), int'(free_count), vecs[i].exp_count);
      check($sformatf("tbl%0d_valid", i), int'(frl_valid), int'(vecs[i].exp_valid));
      check($sformatf("tbl%0d_head", i), int'(free_register_data[0]), vecs[i].exp_head);
    end

    // Recycled slots 35,36 come out last when the list is drained.
    step(1'b1, '0, '0, 0, 0);
    step(1'b0, 6'b110011, '0, 0, 0);
    for (int i = 0; i < 14; i++) step(1'b0, 6'b111111, '0, 0, 0);
    check("drain_slot5", int'(free_register_data[5]), 35);
    step(1'b0, 6'b111111, '0, 0, 0);
    check("drain_count", int'(free_count), 1);
    check("drain_valid", int'(frl_valid), 0);
    check("drain_last", int'(free_register_data[0]), 36);

    // Low list: valid drops, ready is ignored, releases refill.
    step(1'b1, '0, '0, 0, 0);
    for (int i = 0; i < 15; i++) step(1'b0, 6'b111111, '0, 0, 0);
    check("low_count", int'(free_count), 5);
    check("low_valid", int'(frl_valid), 0);
    step(1'b0, 6'b111111, '0, 0, 0);
    check("low_ignored", int'(free_count), 5);
    step(1'b0, '0, 2'b11, 40, 41);
    check("refill_count", int'(free_count), 7);
    check("refill_valid", int'(frl_valid), 1);

    // Release of a register that is still in the list.
    step(1'b1, '0, '0, 0, 0);
    step(1'b0, '0, 2'b01, 50, 0);
`ifdef FRL_DOUBLE_FREE_CHECK_EN
    check("dbl_count", int'(free_count), 95);
    check("dbl_error", int'(frl_error), 1);
    step(1'b0, '0, '0, 0, 0);
    check("dbl_sticky", int'(frl_error), 1);
`else
    check("dbl_count", int'(free_count), 96);
    check("dbl_error", int'(frl_error), 0);
`endif
    step(1'b1, '0, '0, 0, 0);
    check("final_error", int'(frl_error), 0);
    check("final_count", int'(free_count), 95);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
